// File: rtl/fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_responder_if
// Description : Request/response bundle between the fetcher/execute stage
//               (master) and the fetch_responder memory-side block (slave).
//               Also defines the source-selector encodings shared by both
//               sides.
// Ports       : req/we/addr/selector/wdata  master -> slave, request fields
//               rdata/ack/busy/err          slave -> master, response fields
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SELECTOR_MEM
`define SELECTOR_MEM 4'h0
`endif
`ifndef SELECTOR_X
`define SELECTOR_X   4'h1
`endif
`ifndef SELECTOR_Y
`define SELECTOR_Y   4'h2
`endif
`ifndef SELECTOR_A
`define SELECTOR_A   4'h3
`endif

interface fetch_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            selector;
    logic [REG_WIDTH-1:0]  wdata;
    logic [REG_WIDTH-1:0]  rdata;
    logic                  ack;
    logic                  busy;
    logic                  err;

    modport master (
        output req, we, addr, selector, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, selector, wdata,
        output rdata, ack, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : fetch_responder
// Description : Memory-side responder for single-byte requests. One request
//               is accepted at a time and answered with a one-cycle ack. The
//               byte is sourced from the internal work RAM (mirrored through
//               0x0000-0x1FFF), from the X/Y/A register inputs, or from an
//               external bus port with timeout handling.
// Ports       : phi1        clock, all state changes on the rising edge
//               reset_n     asynchronous active-low reset
//               bus         request/response bundle (slave side)
//               x_in/y_in/a_in  register file values
//               ext_req/ext_we/ext_addr/ext_wdata  external access request
//               ext_rdata/ext_ack                  external access response
// Revision    : 1.0 - initial release
// ============================================================================

module fetch_responder #(
    parameter int REG_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int RAM_DEPTH   = 2048,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 16
) (
    input  wire logic                  phi1,
    input  wire logic                  reset_n,

    fetch_responder_if.slave           bus,

    input  wire logic [REG_WIDTH-1:0]  x_in,
    input  wire logic [REG_WIDTH-1:0]  y_in,
    input  wire logic [REG_WIDTH-1:0]  a_in,

    output logic                       ext_req,
    output logic                       ext_we,
    output logic [ADDR_WIDTH-1:0]      ext_addr,
    output logic [REG_WIDTH-1:0]       ext_wdata,
    input  wire logic [REG_WIDTH-1:0]  ext_rdata,
    input  wire logic                  ext_ack
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_idx_w     = $clog2(RAM_DEPTH);
    localparam logic [2:0]         c_wait_init = 3'(WAIT_STATES);
    // One bit wider than the counter so the +1 never wraps before compare.
    localparam logic [8:0]         c_timeout   = 9'(TIMEOUT);
    localparam logic [REG_WIDTH-1:0] c_err_byte = '1;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REG      = 2'd1,
        S_RAM_WAIT = 2'd2,
        S_EXT_WAIT = 2'd3
    } state_t;

    state_t                 r_state;

    // Request fields captured at acceptance
    logic                   r_we;
    logic [c_idx_w-1:0]     r_ram_idx;
    logic [REG_WIDTH-1:0]   r_wdata;
    logic [REG_WIDTH-1:0]   r_reg_val;

    // Wait-state and timeout counters
    logic [2:0]             r_wait_cnt;
    logic [7:0]             r_to_cnt;

    // Work RAM array; deliberately not reset
    logic [REG_WIDTH-1:0]   r_mem [RAM_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [REG_WIDTH-1:0]   w_sel_val;
    logic                   w_in_ram;
    logic [8:0]             w_to_next;
    logic                   w_ram_wr;

    // Register source chosen at acceptance; undefined selectors read as zero.
    always_comb begin
        w_sel_val = '0;
        case (bus.selector)
            `SELECTOR_X: w_sel_val = x_in;
            `SELECTOR_Y: w_sel_val = y_in;
            `SELECTOR_A: w_sel_val = a_in;
            default:     w_sel_val = '0;
        endcase
    end

    // The whole 0x0000-0x1FFF window maps onto the work RAM; the index drops
    // the upper bits so smaller RAMs appear mirrored across the window.
    assign w_in_ram  = (bus.addr[ADDR_WIDTH-1:13] == '0);

    assign w_to_next = {1'b0, r_to_cnt} + 9'd1;

    // The write commits on the final wait edge. Gating with reset_n keeps a
    // write that was in flight when reset arrived from landing in the RAM.
    assign w_ram_wr  = reset_n && (r_state == S_RAM_WAIT) &&
                       (r_wait_cnt == 3'd0) && r_we;

    // ------------------------------------------------------------------------
    // Work RAM write port
    // ------------------------------------------------------------------------
    always_ff @(posedge phi1) begin
        if (w_ram_wr) begin
            r_mem[r_ram_idx] <= r_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Main controller: state, counters and all registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_ram_idx  <= '0;
            r_wdata    <= '0;
            r_reg_val  <= '0;
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
            bus.rdata  <= '0;
            bus.ack    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b0;
            ext_req    <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
        end else begin
            // ack and err are single-cycle pulses
            bus.ack <= 1'b0;
            bus.err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // The ack cycle is also an idle cycle, so a request held
                    // across the ack edge is accepted here back-to-back.
                    if (bus.req) begin
                        r_we      <= bus.we;
                        r_ram_idx <= bus.addr[c_idx_w-1:0];
                        r_wdata   <= bus.wdata;
                        bus.busy  <= 1'b1;

                        if (bus.selector != `SELECTOR_MEM) begin
                            r_reg_val <= w_sel_val;
                            r_state   <= S_REG;
                        end else if (w_in_ram) begin
                            r_wait_cnt <= c_wait_init;
                            r_state    <= S_RAM_WAIT;
                        end else begin
                            ext_req   <= 1'b1;
                            ext_we    <= bus.we;
                            ext_addr  <= bus.addr;
                            ext_wdata <= bus.wdata;
                            r_to_cnt  <= '0;
                            r_state   <= S_EXT_WAIT;
                        end
                    end
                end

                S_REG: begin
                    // Register writes are accepted but have no target here.
                    if (!r_we) begin
                        bus.rdata <= r_reg_val;
                    end
                    bus.ack  <= 1'b1;
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end

                S_RAM_WAIT: begin
                    if (r_wait_cnt != 3'd0) begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end else begin
                        if (!r_we) begin
                            bus.rdata <= r_mem[r_ram_idx];
                        end
                        bus.ack  <= 1'b1;
                        bus.busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                S_EXT_WAIT: begin
                    // ext_ack has priority over a timeout on the same edge.
                    if (ext_ack) begin
                        if (!ext_we) begin
                            bus.rdata <= ext_rdata;
                        end
                        ext_req  <= 1'b0;
                        bus.ack  <= 1'b1;
                        bus.busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_to_next == c_timeout) begin
                        // Aborted access returns 0xFF regardless of direction.
                        r_to_cnt  <= w_to_next[7:0];
                        ext_req   <= 1'b0;
                        bus.rdata <= c_err_byte;
                        bus.ack   <= 1'b1;
                        bus.err   <= 1'b1;
                        bus.busy  <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= w_to_next[7:0];
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_responder
// Description : Directed self-checking bench for fetch_responder with
//               WAIT_STATES=1 and TIMEOUT=16. Expected values are
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SELECTOR_MEM
`define SELECTOR_MEM 4'h0
`endif
`ifndef SELECTOR_X
`define SELECTOR_X   4'h1
`endif
`ifndef SELECTOR_Y
`define SELECTOR_Y   4'h2
`endif
`ifndef SELECTOR_A
`define SELECTOR_A   4'h3
`endif

module tb_fetch_responder;

    logic        phi1;
    logic        reset_n;
    logic [7:0]  x_in, y_in, a_in;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic        ext_ack;

    int checks;
    int errors;
    int edges;

    fetch_responder_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

    fetch_responder #(
        .REG_WIDTH  (8),
        .ADDR_WIDTH (16),
        .RAM_DEPTH  (2048),
        .WAIT_STATES(1),
        .TIMEOUT    (16)
    ) dut (
        .phi1     (phi1),
        .reset_n  (reset_n),
        .bus      (bus),
        .x_in     (x_in),
        .y_in     (y_in),
        .a_in     (a_in),
        .ext_req  (ext_req),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata),
        .ext_ack  (ext_ack)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    // Present a request, let it be sampled on one edge, then drop req.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [3:0] sel,
                          input logic [7:0] d);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.addr     = a;
        bus.selector = sel;
        bus.wdata    = d;
        step();
        bus.req      = 1'b0;
    endtask

    // Count edges after acceptance until ack is seen; -1 if the bound expires.
    task automatic wait_ack(input int max_edges, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_edges) begin
            step();
            n++;
            if (bus.ack) seen = 1'b1;
        end
        if (!seen) n = -1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.selector = '0;
        bus.wdata    = '0;
        x_in         = 8'h00;
        y_in         = 8'h00;
        a_in         = 8'h00;
        ext_rdata    = 8'h00;
        ext_ack      = 1'b0;

        // ---------------- Reset state ----------------
        #12;
        check("rst_ack",     32'(bus.ack),   32'h0);
        check("rst_busy",    32'(bus.busy),  32'h0);
        check("rst_err",     32'(bus.err),   32'h0);
        check("rst_rdata",   32'(bus.rdata), 32'h00);
        check("rst_ext_req", 32'(ext_req),   32'h0);
        check("rst_ext_addr",32'(ext_addr),  32'h0000);
        reset_n = 1'b1;
        step();

        // ---------------- Work RAM with mirror ----------------
        do_req(1'b1, 16'h0012, `SELECTOR_MEM, 8'h5A);
        check("ram_wr_busy", 32'(bus.busy), 32'h1);
        wait_ack(40, edges);
        check("ram_wr_lat",   32'(edges),     32'd2);
        check("ram_wr_rdata", 32'(bus.rdata), 32'h00);
        check("ram_ack_busy", 32'(bus.busy),  32'h0);

        do_req(1'b0, 16'h0812, `SELECTOR_MEM, 8'h00);
        wait_ack(40, edges);
        check("ram_rd_lat",   32'(edges),     32'd2);
        check("ram_rd_mirror",32'(bus.rdata), 32'h5A);

        do_req(1'b1, 16'h1013, `SELECTOR_MEM, 8'h6B);
        wait_ack(40, edges);
        check("ram_wr2_lat",  32'(edges),     32'd2);
        check("ram_wr2_rdata",32'(bus.rdata), 32'h5A);

        // ---------------- Register sources ----------------
        x_in = 8'h33; y_in = 8'h44; a_in = 8'h55;
        do_req(1'b0, 16'h0000, `SELECTOR_X, 8'h00);
        wait_ack(40, edges);
        check("reg_x_lat",   32'(edges),     32'd1);
        check("reg_x_rdata", 32'(bus.rdata), 32'h33);

        do_req(1'b1, 16'h0000, `SELECTOR_Y, 8'h99);
        wait_ack(40, edges);
        check("reg_ywr_lat",   32'(edges),     32'd1);
        check("reg_ywr_rdata", 32'(bus.rdata), 32'h33);

        do_req(1'b0, 16'h0000, `SELECTOR_A, 8'h00);
        wait_ack(40, edges);
        check("reg_a_rdata", 32'(bus.rdata), 32'h55);

        do_req(1'b0, 16'h0000, 4'hF, 8'h00);
        wait_ack(40, edges);
        check("reg_unk_lat",   32'(edges),     32'd1);
        check("reg_unk_rdata", 32'(bus.rdata), 32'h00);

        // ---------------- External read, ack on 3rd edge ----------------
        do_req(1'b0, 16'h4016, `SELECTOR_MEM, 8'h00);
        check("ext_req_e0",  32'(ext_req),  32'h1);
        check("ext_addr",    32'(ext_addr), 32'h4016);
        check("ext_we_rd",   32'(ext_we),   32'h0);
        step();
        check("ext_req_e1",  32'(ext_req),  32'h1);
        step();
        check("ext_req_e2",  32'(ext_req),  32'h1);
        check("ext_noack_e2",32'(bus.ack),  32'h0);
        ext_ack = 1'b1; ext_rdata = 8'hC1;
        step();
        ext_ack = 1'b0;
        check("ext_ack",     32'(bus.ack),   32'h1);
        check("ext_rdata",   32'(bus.rdata), 32'hC1);
        check("ext_err",     32'(bus.err),   32'h0);
        check("ext_req_drop",32'(ext_req),   32'h0);

        // ext_ack while idle is ignored
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        check("idle_ext_ack", 32'(bus.ack), 32'h0);

        // ---------------- External timeout ----------------
        do_req(1'b0, 16'h8000, `SELECTOR_MEM, 8'h00);
        wait_ack(40, edges);
        check("to_lat",     32'(edges),     32'd16);
        check("to_err",     32'(bus.err),   32'h1);
        check("to_rdata",   32'(bus.rdata), 32'hFF);
        check("to_ext_req", 32'(ext_req),   32'h0);
        step();
        check("to_err_pulse", 32'(bus.err), 32'h0);
        check("to_ack_pulse", 32'(bus.ack), 32'h0);

        // External write acked on the first edge: rdata unchanged
        do_req(1'b1, 16'hC000, `SELECTOR_MEM, 8'h77);
        check("extw_we",    32'(ext_we),    32'h1);
        check("extw_wdata", 32'(ext_wdata), 32'h77);
        check("extw_addr",  32'(ext_addr),  32'hC000);
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        check("extw_ack",   32'(bus.ack),   32'h1);
        check("extw_rdata", 32'(bus.rdata), 32'hFF);

        // ext_ack arriving on the timeout edge wins
        do_req(1'b0, 16'h8001, `SELECTOR_MEM, 8'h00);
        repeat (15) step();
        check("race_noack_e15", 32'(bus.ack), 32'h0);
        ext_ack = 1'b1; ext_rdata = 8'h3D;
        step();
        ext_ack = 1'b0;
        check("race_ack",   32'(bus.ack),   32'h1);
        check("race_err",   32'(bus.err),   32'h0);
        check("race_rdata", 32'(bus.rdata), 32'h3D);

        // ---------------- Back-to-back with held req ----------------
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0012; bus.selector = `SELECTOR_MEM;
        step();
        check("b2b_acc1", 32'(bus.busy), 32'h1);
        bus.req = 1'b0;
        step();
        check("b2b_wait1", 32'(bus.ack), 32'h0);
        bus.req = 1'b1; bus.addr = 16'h1813;
        step();
        check("b2b_ack1",   32'(bus.ack),   32'h1);
        check("b2b_rdata1", 32'(bus.rdata), 32'h5A);
        step();
        check("b2b_acc2_busy", 32'(bus.busy), 32'h1);
        check("b2b_acc2_ack",  32'(bus.ack),  32'h0);
        bus.req = 1'b0;
        step();
        check("b2b_wait2", 32'(bus.ack), 32'h0);
        step();
        check("b2b_ack2",   32'(bus.ack),   32'h1);
        check("b2b_rdata2", 32'(bus.rdata), 32'h6B);
        step();
        check("b2b_noextra_ack",  32'(bus.ack),  32'h0);
        check("b2b_noextra_busy", 32'(bus.busy), 32'h0);

        // ---------------- Reset during RAM write wait ----------------
        do_req(1'b1, 16'h0040, `SELECTOR_MEM, 8'h11);
        wait_ack(40, edges);
        check("pre_wr_lat", 32'(edges), 32'd2);
        do_req(1'b1, 16'h0040, `SELECTOR_MEM, 8'hEE);
        reset_n = 1'b0;
        #1;
        check("arst_busy",    32'(bus.busy), 32'h0);
        check("arst_ext_req", 32'(ext_req),  32'h0);
        step();
        check("arst_noack",   32'(bus.ack),  32'h0);
        step();
        reset_n = 1'b1;
        step();
        do_req(1'b0, 16'h0040, `SELECTOR_MEM, 8'h00);
        wait_ack(40, edges);
        check("arst_old_data", 32'(bus.rdata), 32'h11);

        // Reset during external wait drops ext_req at once
        do_req(1'b0, 16'h9000, `SELECTOR_MEM, 8'h00);
        check("arst_ext_pre", 32'(ext_req), 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_ext_drop", 32'(ext_req), 32'h0);
        check("arst_ext_ack",  32'(bus.ack), 32'h0);
        step();
        reset_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_responder.md
# fetch_responder

Memory-side responder for the byte requests the instruction fetcher and execute stage issue on the internal bus. It accepts one request at a time (address, selector, read/write) and returns one byte with a single-cycle acknowledge. The byte comes from one of three sources: the internal 2 KiB work RAM, which is mirrored through 0x0000–0x1FFF; the X, Y or A register inputs; or an external bus port for all other addresses, with wait and timeout handling. The block sits between the fetcher/CPU core and the system bus, and it owns the work RAM array.

## Interface
- REG_WIDTH, 8, data byte width
- ADDR_WIDTH, 16, address width
- RAM_DEPTH, 2048, work RAM bytes; power of two; index is addr[$clog2(RAM_DEPTH)-1:0]
- WAIT_STATES, 1, extra cycles before a work RAM access completes (0–7)
- TIMEOUT, 16, edges spent waiting for ext_ack before the request is aborted (1–255)
- phi1  in  1  clock; all state changes on posedge phi1
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  request valid; sampled only while idle
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  ADDR_WIDTH  request address; latched with req
- selector  in  4  source select: `SELECTOR_MEM, `SELECTOR_X, `SELECTOR_Y, `SELECTOR_A; latched with req
- wdata  in  REG_WIDTH  write byte; latched with req
- x_in, y_in, a_in  in  REG_WIDTH  register file values
- rdata  out  REG_WIDTH  response byte; holds its value until the next read response
- ack  out  1  one-cycle response pulse
- busy  out  1  a request is accepted and outstanding
- err  out  1  pulses with ack when an external access times out
- ext_req  out  1  external access request
- ext_we, ext_addr, ext_wdata  out  1/ADDR_WIDTH/REG_WIDTH  external access fields
- ext_rdata  in  REG_WIDTH  external read data
- ext_ack  in  1  external completion

## Operation
- States: IDLE, REG, RAM_WAIT, EXT_WAIT. ack, err and busy are registered outputs.
- IDLE with req=1 at an edge: latch we/addr/selector/wdata, set busy=1, then branch:
  - selector is X/Y/A, or any value other than MEM: go to REG and latch the register value at the acceptance edge (unknown selector latches 8'h00).
  - selector is MEM and addr[ADDR_WIDTH-1:13]==0: go to RAM_WAIT with wait counter = WAIT_STATES.
  - selector is MEM, any other address: go to EXT_WAIT. Drive ext_req=1, ext_addr=addr, ext_we=we, ext_wdata=wdata; clear the timeout counter.
- REG → IDLE on the next edge.
  - Read: ack=1, rdata = latched value.
  - Write: no register is modified; ack=1 and rdata is unchanged.
- RAM_WAIT, at each edge:
  - Counter nonzero: decrement it.
  - Counter zero: perform the access at ram[addr mod RAM_DEPTH]. A read loads rdata; a write updates the RAM and leaves rdata unchanged. Set ack=1 and go to IDLE.
- EXT_WAIT, at each edge:
  - ext_ack=1: a read captures ext_rdata into rdata. Set ext_req=0, ack=1, go to IDLE.
  - ext_ack=0: increment the counter. When it reaches TIMEOUT, set ext_req=0, ack=1, err=1, rdata=8'hFF (even for writes) and go to IDLE.
  - ext_ack and timeout on the same edge: ext_ack wins and err stays 0.
- The ack cycle is an IDLE cycle, so a req sampled at the edge that ends the ack cycle is accepted. busy is 0 during that cycle.
- req while busy is ignored. The requester must hold req until it sees ack; a held req after ack starts a new transaction.
- ext_ack while not in EXT_WAIT is ignored.
- Mirroring: 0x0800, 0x1000 and 0x1800 alias 0x0000 when RAM_DEPTH=2048.

## Timing
- Reset (async): ack=0, err=0, busy=0, rdata=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, state IDLE, counters 0. RAM contents are not reset.
- Reset asserted mid-transaction aborts the access immediately. ext_req drops asynchronously, no ack is issued, and a RAM write still in wait is not performed.
- Latency, with acceptance at edge E:
  - register: ack high after edge E+1.
  - work RAM: ack high after edge E+1+WAIT_STATES.
  - external: ack high after the first edge E+k (k≥1) that samples ext_ack=1, or after edge E+TIMEOUT on timeout.
- ext_* fields are stable from edge E until the edge that drops ext_req.
- Minimum throughput is one transaction per 2 cycles (register or WAIT_STATES=0 RAM).

## Test plan
- Reset, then write 0x5A to 0x0012 and read 0x0812 (WAIT_STATES=1) → ack after 2 edges on each access; the read returns rdata=0x5A through the mirror.
- x_in=0x33: read with selector X → ack after 1 edge, rdata=0x33. Write with selector Y, wdata=0x99 → ack given, rdata stays 0x33.
- Read 0x4016; ext_ack returned on the 3rd edge with ext_rdata=0xC1 → ext_req high for 3 cycles, ext_addr=0x4016, ack with rdata=0xC1, err=0.
- Read 0x8000 with ext_ack never asserted, TIMEOUT=16 → ack and err high after edge E+16, rdata=0xFF, ext_req low.
- req held high through two RAM reads, with new addr presented in the ack cycle → second request accepted at the edge ending the ack cycle; a req toggled while busy causes no extra ack.
- reset_n pulsed low during a RAM write wait → no ack, ext_req=0; a subsequent read of that address returns the old contents.
